// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential instruction fetch with a 2-entry response buffer and redirect flush
package memory_pkg;
  localparam logic [31:0] MAP_IMEM_BASE = 32'h0000_0000;
endpackage

module ifetch_unit #(
  parameter logic [31:0] RESET_PC = memory_pkg::MAP_IMEM_BASE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o
);
  logic [31:0] pc_q, inflight_pc_q;
  logic        inflight_q, rd_q, wr_q;
  logic [1:0]  count;
  logic [31:0] fifo_pc [2];
  logic [31:0] fifo_instr [2];
  logic        pop, push;
  logic [2:0]  occ;
  always_comb begin
    if_valid_o  = rst_i & ~redirect_i & (count != 2'd0);
    pop         = if_valid_o & if_ready_i;
    push        = inflight_q & ~redirect_i;
    // occupancy after this cycle, counting the response still in flight
    occ         = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
    imem_req_o  = rst_i & fetch_en_i & ~redirect_i & (occ < 3'd2);
    imem_addr_o = pc_q;
    if_pc_o     = if_valid_o ? fifo_pc[rd_q] : '0;
    if_instr_o  = if_valid_o ? fifo_instr[rd_q] : '0;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      count         <= '0;
      fifo_pc[0]    <= '0;
      fifo_pc[1]    <= '0;
      fifo_instr[0] <= '0;
      fifo_instr[1] <= '0;
    end else if (redirect_i) begin
      pc_q       <= {redirect_pc_i[31:2], 2'b00};
      inflight_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      count      <= '0;
    end else begin
      inflight_q <= imem_req_o;
      if (imem_req_o) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 32'd4;
      end
      if (push) begin
        fifo_pc[wr_q]    <= inflight_pc_q;
        fifo_instr[wr_q] <= imem_instr_i;
        wr_q             <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch initiator that drives the instruction memory's native request/address interface and delivers sequentially fetched instructions with their PCs to the decode stage through a valid/ready handshake. It absorbs the memory's fixed one-cycle read latency with a 2-entry buffer, so decode back-pressure never loses or duplicates an instruction. Branch and trap redirects flush the buffer and discard any in-flight response. The block sits between the core's PC/redirect logic and `imem`.

## Interface
- `RESET_PC`, default `memory_pkg::MAP_IMEM_BASE`: first fetch address after reset; bits [1:0] must be 0.
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `fetch_en_i` in 1: when 0, no new memory requests are issued; an in-flight response still completes into the buffer.
- `redirect_i` in 1: one-cycle pulse; the next fetch address becomes `redirect_pc_i`.
- `redirect_pc_i` in 32: redirect target; bits [1:0] are ignored and treated as 0.
- `imem_req_o` out 1: read request to memory (combinational).
- `imem_addr_o` out 32: read address, equal to `pc_q`.
- `imem_instr_i` in 32: memory read data, valid the cycle after a request.
- `if_valid_o` out 1: buffer head holds an instruction.
- `if_ready_i` in 1: decode accepts the head.
- `if_pc_o` out 32: PC of the head; 0 when `if_valid_o`=0.
- `if_instr_o` out 32: instruction at the head; 0 when `if_valid_o`=0.

## Operation
- State:
  - `pc_q`: next address to request.
  - `inflight_q`: a request was issued last cycle.
  - `inflight_pc_q`: address of that request.
  - A 2-entry FIFO of {pc, instr} with `count` in 0..2.
- Pop: `pop = if_valid_o & if_ready_i`.
- Issue condition: `imem_req_o = rst_i & fetch_en_i & ~redirect_i & (count + inflight_q - pop < 2)`. This allows one instruction per cycle in steady state.
- On issue:
  - `inflight_q` <= 1 and `inflight_pc_q` <= `pc_q`.
  - `pc_q` <= `pc_q + 4`, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - Otherwise `inflight_q` <= 0.
- Response: when `inflight_q`=1, {`inflight_pc_q`, `imem_instr_i`} is pushed into the FIFO. `imem_instr_i` is ignored when `inflight_q`=0.
- The push/pop condition guarantees the FIFO never overflows. Simultaneous push and pop keep `count` unchanged and preserve order.
- Redirect (`redirect_i`=1):
  - In the same cycle, `if_valid_o` is forced to 0, so no handshake occurs, and `imem_req_o` is forced to 0.
  - At the edge: FIFO is cleared, `inflight_q` <= 0, `pc_q` <= {`redirect_pc_i[31:2]`, 2'b00}.
  - The stale response arriving the next cycle is dropped.
- `fetch_en_i` does not affect popping or the response push.
- Out-of-range addresses are passed through unchanged. Whatever data memory returns (0) is delivered.

## Timing
- Reset values (asynchronous on `rst_i`=0):
  - `pc_q`=RESET_PC, `count`=0, `inflight_q`=0, FIFO storage 0.
  - Outputs: `imem_req_o`=0, `imem_addr_o`=RESET_PC, `if_valid_o`=0, `if_pc_o`=0, `if_instr_o`=0.
- Reset assertion mid-operation clears everything immediately. The pending response is discarded.
- First edge with `rst_i`=1 and `fetch_en_i`=1: request for RESET_PC is issued in that cycle.
- Fetch latency: a request in cycle t produces `if_valid_o` for that PC in cycle t+2.
- Redirect latency: redirect in cycle t gives a request for the target in t+1 and `if_valid_o` with the target PC in t+3.
- Back-pressure: with `if_ready_i`=0, requests stop once `count + inflight_q` = 2. The FIFO then holds exactly 2 entries and the head stays stable until popped.
- Simultaneous redirect and `if_ready_i`=1: the redirect wins and nothing is popped.
- `fetch_en_i` deasserted: the in-flight response still lands and can be popped.

## Test plan
- Reset release, `RESET_PC`=0x0000_0000, ready=1, memory word i = 0x1000_0000+i:
  - Requests 0x0, 0x4, 0x8, … on consecutive cycles.
  - `if_valid_o` first high 2 cycles after the first request.
  - Then (pc, instr) = (0x0, 0x1000_0000), (0x4, 0x1000_0001), … one per cycle.
- Ready held 0 for 6 cycles after the first valid:
  - `count` saturates at 2 and `imem_req_o` drops.
  - Head stays (0x0, 0x1000_0000).
  - After release, the PCs are consecutive with no gap or duplicate.
- Redirect to 0x0000_0102 while the FIFO is full and a request is in flight:
  - `imem_req_o`=0 that cycle.
  - Next cycle `imem_addr_o`=0x100.
  - `if_pc_o`=0x100 valid 3 cycles after the redirect.
  - No pre-redirect PC appears afterwards.
- Redirect coincident with valid & ready: `if_valid_o` reads 0 that cycle and the popped-entry count is unchanged.
- Redirect to 0xFFFF_FFFC: requests 0xFFFF_FFFC then 0x0000_0000.
- `rst_i` pulsed low between clock edges while streaming: `if_valid_o`, `imem_req_o` and `count` go to 0 immediately. The restart is identical to the first scenario.
